// File: rtl/spi_vip_master_arbiter.sv
// spi_vip_master_arbiter: round-robin arbiter in front of one SPI master frame sequencer.
// Define SPI_VIP_ARB_STRICT_PRIO_EN to grant the lowest-index valid requester instead.
module spi_vip_master_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int CPOL         = 0,
    parameter int CPHA         = 0,
    parameter int INV_CS       = 0,
    parameter int DATA_DLENGTH = 16,
    parameter int CLK_DIV      = 4,
    parameter int CS_TO_SCLK   = 2,
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*DATA_DLENGTH-1:0] req_data,
    output logic                            rsp_valid,
    output logic [IW-1:0]                   rsp_id,
    output logic [DATA_DLENGTH-1:0]         rsp_data,
    output logic                            busy,
    output logic                            m_spi_sclk,
    output logic                            m_spi_mosi,
    input  logic                            m_spi_miso,
    output logic                            m_spi_cs
);
    localparam int D  = DATA_DLENGTH;
    localparam int EW = $clog2(2*D+1);
    localparam int DW = $clog2(CLK_DIV+1);
    localparam int CW = $clog2(CS_TO_SCLK+1);
    localparam logic SCLK_IDLE = 1'(CPOL);
    localparam logic CS_OFF    = (INV_CS == 0);

    typedef enum logic [2:0] {IDLE, GRANT, SETUP, SHIFT, HOLD, RESP} state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      gnt_q, gnt_d, ptr_q, ptr_d, pick;
    logic [D-1:0]       tx_q, tx_d, rx_q, rx_d, word;
    logic [EW-1:0]      tgl_q, tgl_d;
    logic [DW-1:0]      div_q, div_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               sclk_q, sclk_d, mosi_q, mosi_d;
    logic [IW-1:0]      rsp_id_q, rsp_id_d;
    logic [D-1:0]       rsp_data_q, rsp_data_d;
    logic [NUM_REQ-1:0] ready_q;
    logic               rsp_valid_q, busy_q, cs_q;
    logic               lead, last;

    assign word = req_data[int'(gnt_q)*D +: D];
    assign lead = ~tgl_q[0];
    assign last = tgl_q == EW'(2*D-1);

    // Descending scan so the lowest offset from the search origin wins.
    always_comb begin
        pick = '0;
        for (int i = NUM_REQ-1; i >= 0; i--) begin
`ifdef SPI_VIP_ARB_STRICT_PRIO_EN
            if (req_valid[i]) pick = IW'(i);
`else
            if (req_valid[(int'(ptr_q) + i) % NUM_REQ]) pick = IW'((int'(ptr_q) + i) % NUM_REQ);
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        ptr_d      = ptr_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        tgl_d      = tgl_q;
        div_d      = div_q;
        cnt_d      = cnt_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            IDLE: if (|req_valid) begin
                gnt_d   = pick;
                state_d = GRANT;
            end
            GRANT: begin
                state_d = req_valid[gnt_q] ? SETUP : IDLE;
                if (req_valid[gnt_q]) begin
                    // CPHA=0 presents the MSB during setup, so the shifter starts one bit ahead.
                    tx_d   = (CPHA == 0) ? word << 1 : word;
                    mosi_d = (CPHA == 0) & word[D-1];
                    rx_d   = '0;
                    cnt_d  = '0;
`ifndef SPI_VIP_ARB_STRICT_PRIO_EN
                    ptr_d  = (gnt_q == IW'(NUM_REQ-1)) ? '0 : gnt_q + 1'b1;
`endif
                end
            end
            SETUP: if (cnt_q == CW'(CS_TO_SCLK-1)) begin
                state_d = SHIFT;
                div_d   = '0;
                tgl_d   = '0;
            end else cnt_d = cnt_q + 1'b1;
            SHIFT: if (div_q == DW'(CLK_DIV-1)) begin
                div_d  = '0;
                tgl_d  = tgl_q + 1'b1;
                sclk_d = ~sclk_q;
                if (lead == (CPHA == 0)) rx_d = {rx_q[D-2:0], m_spi_miso};
                else if (!last) begin
                    mosi_d = tx_q[D-1];
                    tx_d   = tx_q << 1;
                end
                if (last) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end else div_d = div_q + 1'b1;
            HOLD: if (cnt_q == CW'(CS_TO_SCLK-1)) begin
                state_d    = RESP;
                rsp_id_d   = gnt_q;
                rsp_data_d = rx_q;
                mosi_d     = 1'b0;
            end else cnt_d = cnt_q + 1'b1;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so each one lines up with its state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            ptr_q       <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            tgl_q       <= '0;
            div_q       <= '0;
            cnt_q       <= '0;
            sclk_q      <= SCLK_IDLE;
            mosi_q      <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            ready_q     <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cs_q        <= CS_OFF;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            ptr_q       <= ptr_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            tgl_q       <= tgl_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            ready_q     <= (state_d == GRANT) ? NUM_REQ'(1) << gnt_d : '0;
            rsp_valid_q <= state_d == RESP;
            busy_q      <= state_d != IDLE;
            cs_q        <= (state_d inside {SETUP, SHIFT, HOLD}) ? ~CS_OFF : CS_OFF;
        end
    end

    assign req_ready  = ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_data   = rsp_data_q;
    assign busy       = busy_q;
    assign m_spi_sclk = sclk_q;
    assign m_spi_mosi = mosi_q;
    assign m_spi_cs   = cs_q;
endmodule
